router_sync_mp: RTL
===================

Name: router_sync_mp

Overview:
- Parametrised synchroniser between the router FSM, the register block and NUM_PORTS output FIFOs.
- Latches the destination address of each packet and steers the FIFO write enable.
- Muxes the selected FIFO's full flag back to the FSM and drives per-port valid outputs.
- Runs per-port read-timeout watchdogs that issue a one-cycle soft reset to a FIFO whose valid data is not read within TIMEOUT cycles. Also flags packets addressed to a non-existent port.

Parameters:
- NUM_PORTS, 3, number of output FIFOs/ports (2..8).
- ADDR_W, 2, width of the address field in data_in; must satisfy 2**ADDR_W >= NUM_PORTS.
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (2..1023).
- CNT_W, 10, watchdog counter width; must hold TIMEOUT-1.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- resetn, input, 1, synchronous, active-low reset.
- detect_add, input, 1, FSM strobe: data_in carries the header address this cycle.
- data_in, input, ADDR_W, destination address.
- write_enb_reg, input, 1, FSM request to write the current byte to the addressed FIFO.
- full, input, NUM_PORTS, per-FIFO full flags.
- empty, input, NUM_PORTS, per-FIFO empty flags.
- read_enb, input, NUM_PORTS, per-port read strobes from the destination.
- write_enb, output, NUM_PORTS, one-hot FIFO write enables (combinational).
- fifo_full, output, 1, full flag of the addressed FIFO (combinational).
- vld_out, output, NUM_PORTS, per-port valid, equal to ~empty (combinational).
- soft_reset, output, NUM_PORTS, registered one-cycle FIFO flush pulses.
- addr_err, output, 1, registered; high while the latched address is >= NUM_PORTS.

Behaviour:
- Reset (resetn=0 at clock edge):
  - addr_q = 0, addr_err = 0, all watchdog counters = 0, soft_reset = 0.
  - Combinational outputs follow the reset state, so write_enb = 0 unless write_enb_reg is high. In that case it reflects addr_q = 0.
- Address latch:
  - When detect_add=1, addr_q <= data_in at the next edge. Otherwise addr_q holds.
  - addr_err <= (data_in >= NUM_PORTS) on the same edge; it holds until the next detect_add.
- write_enb:
  - If write_enb_reg=1 and addr_q < NUM_PORTS: one-hot bit addr_q set.
  - Otherwise all zero. An invalid address never writes any FIFO.
- fifo_full:
  - full[addr_q] when addr_q < NUM_PORTS.
  - 1 when the address is invalid, so the FSM stalls/drops rather than writing.
- vld_out[i] = ~empty[i], zero latency.
- Watchdog, per port i, independent:
  - If vld_out[i]=1 and read_enb[i]=0: counter increments.
  - If counter == TIMEOUT-1 in such a cycle: next edge drives soft_reset[i] <= 1 and counter <= 0.
  - If read_enb[i]=1 or vld_out[i]=0: counter <= 0 and soft_reset[i] <= 0. A read in the same cycle as terminal count wins, so no soft reset is issued.
  - soft_reset[i] is high for exactly one cycle per timeout event.
  - If the FIFO is still non-empty after the flush, counting restarts from 0. Its next pulse is TIMEOUT cycles later.
- Simultaneous events:
  - detect_add in the same cycle as write_enb_reg: write_enb uses the old addr_q. The new address takes effect the following cycle.
  - Watchdogs are unaffected by detect_add and write traffic.
- Reset mid-count: counters and pulses clear at the reset edge; no pulse is emitted.

Optional Feature:
- Macro SYNC_TIMEOUT_STATUS_EN.
- When defined, adds two ports:
  - status_clr, input, 1.
  - timeout_status, output, NUM_PORTS, registered, sticky.
- Behaviour with the macro:
  - timeout_status[i] sets on the cycle soft_reset[i] asserts.
  - It clears on status_clr=1 or reset. A set in the same cycle as status_clr wins.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- NUM_PORTS=3: detect_add=1, data_in=2, then write_enb_reg=1 -> write_enb=3'b100; fifo_full tracks full[2] (full=3'b100 -> fifo_full=1).
- data_in=3 with NUM_PORTS=3 -> addr_err=1 next cycle; write_enb=0 under write_enb_reg=1; fifo_full=1. A following detect_add with data_in=0 -> addr_err=0.
- TIMEOUT=30, empty[1]=0, read_enb[1]=0 held -> soft_reset[1] high exactly on the 31st edge after valid rises, for 1 cycle; it repeats 30 cycles later if still non-empty.
- read_enb[0] pulsed at cycle 29 of 30 -> counter clears, no soft_reset[0]; empty[0]=1 mid-count -> counter clears.
- resetn=0 asserted at count 20 on port 2 -> soft_reset=0, addr_err=0, write_enb=0. A fresh timeout then takes the full 30 cycles.
- SYNC_TIMEOUT_STATUS_EN: timeout on port 0 -> timeout_status=3'b001, held. status_clr=1 -> 3'b000. Coincident timeout and status_clr -> bit stays 1.

Source files
------------

// File: rtl/router_sync_mp.sv
// router_sync_mp: glue between the router FSM, the register block and NUM_PORTS
// output FIFOs. Latches the packet destination, steers the FIFO write enable,
// returns the addressed FIFO's full flag, drives per-port valid, and runs one
// read-timeout watchdog per port that flushes a FIFO left unread too long.
// Packets addressed beyond the last port raise addr_err and never write a FIFO.
// Optional build macro SYNC_TIMEOUT_STATUS_EN adds status_clr / timeout_status,
// a sticky per-port record of watchdog flushes.
module router_sync_mp #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30,
  parameter int CNT_W     = 10
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
`ifdef SYNC_TIMEOUT_STATUS_EN
  ,
  input  logic                 status_clr,
  output logic [NUM_PORTS-1:0] timeout_status
`endif
);

  // One extra bit so the port count still fits when 2**ADDR_W == NUM_PORTS.
  localparam logic [ADDR_W:0]  NUM_PORTS_V = (ADDR_W+1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] TERM_CNT    = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    addr_q;
  logic [CNT_W-1:0]     wd_cnt [NUM_PORTS];
  // A port is "idle" when it holds valid data that nobody is reading.
  logic [NUM_PORTS-1:0] wd_idle;
  // Idle in the cycle the counter sits at terminal count: flush next edge.
  logic [NUM_PORTS-1:0] wd_expire;

  // Capture the header address and whether it names a real port.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q   <= '0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      addr_q   <= data_in;
      addr_err <= ({1'b0, data_in} >= NUM_PORTS_V);
    end
  end

  // Decode the latched address; an address matching no port writes nothing
  // and reports full so the FSM stalls instead of writing.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  // Per-port watchdog qualifiers; a read always beats terminal count.
  always_comb begin
    wd_idle   = '0;
    wd_expire = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wd_idle[i]   = vld_out[i] & ~read_enb[i];
      wd_expire[i] = wd_idle[i] & (wd_cnt[i] == TERM_CNT);
    end
  end

  // Count unread-valid cycles per port and emit a one-cycle flush on expiry.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      soft_reset <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        wd_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wd_expire[i]) begin
          wd_cnt[i]     <= '0;
          soft_reset[i] <= 1'b1;
        end else if (wd_idle[i]) begin
          wd_cnt[i]     <= wd_cnt[i] + CNT_W'(1);
          soft_reset[i] <= 1'b0;
        end else begin
          wd_cnt[i]     <= '0;
          soft_reset[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SYNC_TIMEOUT_STATUS_EN
  // Sticky flush record; a new expiry wins over a coincident clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      timeout_status <= '0;
    end else begin
      timeout_status <= (status_clr ? '0 : timeout_status) | wd_expire;
    end
  end
`endif

endmodule
